// File: rtl/dmem_responder_if.sv
// Core data-port bundle: request fields driven by the core, load data returned
// combinationally by the responder in the same cycle.
interface dmem_responder_if;
  logic        mem_w;
  logic        mem_r;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [2:0]  DMType;
  logic [31:0] Data_out;

  modport master (output mem_w, mem_r, Addr_in, Data_in, DMType, input Data_out);
  modport slave  (input mem_w, mem_r, Addr_in, Data_in, DMType, output Data_out);
endinterface

// File: rtl/dmem_responder.sv
// Data-side memory responder: byte-lane RAM with async read, a 4-register MMIO
// window (LED, cycle count, store count, error clear) and sticky misalign capture.

module dmem_lane #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

module dmem_responder #(
  parameter int          DEPTH_WORDS = 128,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic [15:0]       led_out,
  output logic              misalign_err,
  output logic [31:0]       err_addr
);
  localparam int          NUM_LANES = 4;
  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  typedef struct packed {
    size_e sz;
    logic  sgn;
    logic  ram_hit;
    logic  mmio_hit;
    logic  bad_align;
  } dec_t;

  dec_t dec;

  logic [NUM_LANES-1:0]       lane_be;
  logic [NUM_LANES-1:0][7:0]  lane_wdata;
  logic [NUM_LANES-1:0][7:0]  lane_rdata;
  logic [AW-1:0]              word_idx;
  logic                       ok_w, ok_r, misalign, ram_st, ram_we, mmio_wr;
  logic [31:0]                rword, ram_load, mmio_load;
  logic [15:0]                sel_h;
  logic [7:0]                 sel_b;

  logic [15:0] led_q,   led_d;
  logic [31:0] cyc_q,   cyc_d;
  logic [31:0] st_q,    st_d;
  logic        err_q,   err_d;
  logic [31:0] eaddr_q, eaddr_d;

  always_comb begin
    dec = '0;
    unique case (bus.DMType)
      3'b001:  begin dec.sz = SZ_HALF; dec.sgn = 1'b1; end
      3'b010:  begin dec.sz = SZ_HALF; dec.sgn = 1'b0; end
      3'b011:  begin dec.sz = SZ_BYTE; dec.sgn = 1'b1; end
      3'b100:  begin dec.sz = SZ_BYTE; dec.sgn = 1'b0; end
      default: begin dec.sz = SZ_WORD; dec.sgn = 1'b0; end
    endcase
    dec.ram_hit  = {1'b0, bus.Addr_in} < RAM_BYTES;
    dec.mmio_hit = bus.Addr_in[31:4] == MMIO_BASE[31:4];
    // register window only speaks whole words
    dec.bad_align = (dec.sz == SZ_HALF && bus.Addr_in[0]) ||
                    (dec.sz == SZ_WORD && bus.Addr_in[1:0] != 2'b00) ||
                    (dec.mmio_hit && dec.sz != SZ_WORD);
  end

  assign misalign = (bus.mem_w | bus.mem_r) & dec.bad_align;
  assign ok_w     = bus.mem_w & ~dec.bad_align;
  assign ok_r     = bus.mem_r & ~dec.bad_align;
  assign ram_st   = ok_w & dec.ram_hit;
  assign ram_we   = ram_st & ~reset;
  assign mmio_wr  = ok_w & dec.mmio_hit & ~dec.ram_hit;
  assign word_idx = bus.Addr_in[AW+1:2];

  // store data is right-aligned, so replicate it across lanes and let the
  // byte enables pick which lanes actually take it
  always_comb begin
    lane_be    = '0;
    lane_wdata = bus.Data_in;
    unique case (dec.sz)
      SZ_BYTE: lane_wdata = {NUM_LANES{bus.Data_in[7:0]}};
      SZ_HALF: lane_wdata = {2{bus.Data_in[15:0]}};
      default: lane_wdata = bus.Data_in;
    endcase
    for (int l = 0; l < NUM_LANES; l++) begin
      unique case (dec.sz)
        SZ_BYTE: lane_be[l] = bus.Addr_in[1:0] == 2'(l);
        SZ_HALF: lane_be[l] = bus.Addr_in[1] == (l >= 2);
        default: lane_be[l] = 1'b1;
      endcase
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dmem_lane #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk     (clk),
      .we_i    (ram_we & lane_be[l]),
      .addr_i  (word_idx),
      .wdata_i (lane_wdata[l]),
      .rdata_o (lane_rdata[l])
    );
  end

  always_comb begin
    rword = lane_rdata;
    sel_b = lane_rdata[bus.Addr_in[1:0]];
    sel_h = bus.Addr_in[1] ? rword[31:16] : rword[15:0];
    unique case (dec.sz)
      SZ_BYTE: ram_load = {{24{dec.sgn & sel_b[7]}}, sel_b};
      SZ_HALF: ram_load = {{16{dec.sgn & sel_h[15]}}, sel_h};
      default: ram_load = rword;
    endcase
    unique case (bus.Addr_in[3:2])
      2'd0:    mmio_load = {16'b0, led_q};
      2'd1:    mmio_load = cyc_q;
      2'd2:    mmio_load = st_q;
      default: mmio_load = {31'b0, err_q};
    endcase
  end

  always_comb begin
    bus.Data_out = '0;
    if (ok_r) begin
      if (dec.ram_hit)       bus.Data_out = ram_load;
      else if (dec.mmio_hit) bus.Data_out = mmio_load;
    end
  end

  always_comb begin
    led_d   = led_q;
    cyc_d   = cyc_q + 32'd1;
    st_d    = st_q;
    err_d   = err_q;
    eaddr_d = eaddr_q;
    if (ram_st) st_d = st_q + 32'd1;
    if (mmio_wr && bus.Addr_in[3:2] == 2'd0) led_d = bus.Data_in[15:0];
    // first offender wins until software clears via the +0xC register
    if (misalign) begin
      err_d = 1'b1;
      if (!err_q) eaddr_d = bus.Addr_in;
    end else if (mmio_wr && bus.Addr_in[3:2] == 2'd3) begin
      err_d   = 1'b0;
      eaddr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q   <= '0;
      cyc_q   <= '0;
      st_q    <= '0;
      err_q   <= 1'b0;
      eaddr_q <= '0;
    end else begin
      led_q   <= led_d;
      cyc_q   <= cyc_d;
      st_q    <= st_d;
      err_q   <= err_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign led_out      = led_q;
  assign misalign_err = err_q;
  assign err_addr     = eaddr_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side memory responder for the pipelined RV32 core. It sits at the far end of the core's data port (address, write data, mem_w, mem_r, DMType) and returns load data in the same cycle the request is presented.
- It provides a word-organised data RAM with byte, halfword and word access. It also provides a small memory-mapped register window: LED register, free-running cycle counter, store counter, and an error-clear register.
- It also detects misaligned accesses and reports them through a sticky flag.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit RAM words. The RAM region is byte addresses 0 to DEPTH_WORDS*4-1.
- MMIO_BASE, 32'hFFFF_0000, base byte address of the register window. It is 16 bytes, 4 word registers.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- mem_w  in  1  store request this cycle
- mem_r  in  1  load request this cycle
- Addr_in  in  32  byte address of the access
- Data_in  in  32  store data, right-aligned: byte in [7:0], halfword in [15:0]
- DMType  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 are treated as word
- Data_out  out  32  load data, combinational from current inputs and state
- led_out  out  16  LED register contents
- misalign_err  out  1  sticky misalignment flag
- err_addr  out  32  address of the first misaligned access since the flag was last cleared

Behaviour:
- Reset (sync, high):
  - led_out, the cycle counter, the store counter, misalign_err and err_addr all become 0.
  - RAM contents are not reset.
  - Reset has priority over every request in the same cycle; a store presented during reset is dropped.
- Address decode:
  - RAM hit: Addr_in < DEPTH_WORDS*4.
  - MMIO hit: Addr_in[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped: loads return 0 and stores are ignored, with no error.
- Alignment:
  - Halfword access requires Addr_in[0]=0. Word access requires Addr_in[1:0]=00.
  - Any MMIO access must be a word access; a byte or halfword MMIO access counts as misaligned.
  - A misaligned access that has mem_w or mem_r asserted is suppressed: no RAM or register write, and Data_out=0.
  - On the next edge it sets misalign_err. err_addr captures Addr_in only if misalign_err was 0.
- RAM load (mem_r, aligned, RAM hit):
  - Zero cycles of latency; the word is read asynchronously at Addr_in[log2(DEPTH_WORDS)+1:2].
  - The byte or halfword is selected by Addr_in[1:0] and sign- or zero-extended according to DMType.
- RAM store (mem_w, aligned, RAM hit):
  - Written on the rising edge. Only the addressed byte lanes change: byte writes lane Addr_in[1:0], halfword writes lanes {Addr_in[1],0} and {Addr_in[1],1}, word writes all lanes.
  - The store counter increments by 1 and wraps at 2^32.
- mem_w and mem_r both asserted: the store is performed. Data_out shows the pre-write contents during that cycle.
- Data_out is 0 whenever mem_r=0.
- MMIO map (word offsets from MMIO_BASE):
  - +0x0 LED, RW. A store writes Data_in[15:0]; a load returns {16'b0, led_out}.
  - +0x4 cycle counter, RO. Increments every non-reset cycle and wraps from FFFF_FFFF to 0. A load returns the pre-increment value.
  - +0x8 store counter, RO. Counts RAM stores only.
  - +0xC error clear. Any store clears misalign_err and err_addr to 0. A load returns {31'b0, misalign_err}.
  - Stores to the RO registers are ignored.
- Clear vs. new error in the same cycle cannot happen, because the clear register is only reachable by an aligned word store.

Test Plan:
- Reset, then store word 0xDEADBEEF to addr 0x10 and load word from 0x10 -> Data_out=0xDEADBEEF; store counter=1.
- Store byte 0x80 to 0x13, then load byte signed from 0x13 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word from 0x10 -> 0x80ADBEEF.
- Store halfword 0x1234 to 0x22 over a word 0 -> word load from 0x20 gives 0x12340000. Load half signed from 0x22 after storing 0x8001 -> 0xFFFF8001.
- Load word from 0x15 -> Data_out=0, misalign_err=1 next cycle, err_addr=0x15. Then store half to 0x17 -> err_addr stays 0x15 and RAM is unchanged. Then store word to 0xFFFF000C -> flag=0 and err_addr=0.
- Store word 0x0001ABCD to 0xFFFF0000 -> led_out=0xABCD. Store to 0xFFFF0004 is ignored. Two loads of 0xFFFF0004 five cycles apart differ by 5.
- Assert reset for one cycle while mem_w targets 0x30 -> store dropped, led_out=0, counters=0, RAM word 0x30 keeps its prior value.
